// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO controller family.
// Provides the occupancy-counter width function and the packed status view
// that monitors and coverage collectors use to sample FIFO flags in one go.
package sync_fifo_pkg;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one read port.
// Read port is combinational when SYNC_FIFO_FWFT_EN is defined, otherwise a
// registered read (reset to 0, holds its value when rd_en is low).
// Ports: clk, reset_n, wr_en/wr_addr/wr_data (write), rd_en/rd_addr/rd_data (read).
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is visible combinationally; no read register exists.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = reset_n ^ rd_en;
    assign rd_data        = mem[rd_addr];
`else
    logic [DATA_WIDTH-1:0] rd_q;

    // On a simultaneous write/read of the same slot (full FIFO) the old
    // head is returned, which is the word actually being popped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, threshold flags,
// read-valid strobe and sticky overflow/underflow flags around fifo_mem.
// Ports: clk/reset_n (sync active-low), wr_en/wr_data, rd_en/rd_data/rd_valid,
// full/empty/almost_full/almost_empty/count, overflow/underflow/err_clr.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CW     = cnt_w(DEPTH);

    localparam fifo_status_t RST_STATUS = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0,
        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
    };

    // Elaboration-time parameter legality.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nxt;
    fifo_status_t      stat_q;
    logic              rd_ok;
    logic              wr_ok;

    // Accept decisions use registered state only; a write to a full FIFO
    // succeeds when a pop frees a slot in the same cycle.
    assign rd_ok = rd_en && !stat_q.empty;
    assign wr_ok = wr_en && (!stat_q.full || rd_ok);

    always_comb begin
        cnt_nxt = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_nxt = cnt_q + CW'(1);
            2'b01:   cnt_nxt = cnt_q - CW'(1);
            default: cnt_nxt = cnt_q;
        endcase
    end

    // Flags come from the next count so they line up with count.
    // Error flags: a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            stat_q <= RST_STATUS;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt_q               <= cnt_nxt;
            stat_q.full         <= (cnt_nxt == CW'(DEPTH));
            stat_q.empty        <= (cnt_nxt == '0);
            stat_q.almost_full  <= (cnt_nxt >= CW'(AF_THRESH));
            stat_q.almost_empty <= (cnt_nxt <= CW'(AE_THRESH));
            stat_q.overflow     <= (wr_en && !wr_ok) ? 1'b1 :
                                   err_clr ? 1'b0 : stat_q.overflow;
            stat_q.underflow    <= (rd_en && !rd_ok) ? 1'b1 :
                                   err_clr ? 1'b0 : stat_q.underflow;
        end
    end

    // Gating with reset_n keeps the reset cycle from completing a transfer.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_ok && reset_n),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok && reset_n),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_valid = !stat_q.empty;
`else
    logic rd_valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

    assign count        = cnt_q;
    assign full         = stat_q.full;
    assign empty        = stat_q.empty;
    assign almost_full  = stat_q.almost_full;
    assign almost_empty = stat_q.almost_empty;
    assign overflow     = stat_q.overflow;
    assign underflow    = stat_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (registered-read build,
// DATA_WIDTH=8, DEPTH=16, AF=14, AE=2). Outputs are sampled 1 time unit
// after each rising edge; inputs are changed at the same point.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        logic [9:0] exp_v;
        reset_n = 1'b0; idle(); wr_data = 8'h00;
        step(); step();
        reset_n = 1'b1;
        // {full, empty, af, ae, rd_valid, ovf, unf, count[2:0]}
        got   = {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow, count[2:0]};
        exp_v = 10'b01_0100_0000;
        n_checks++;
        if (got !== exp_v) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=%b", got, exp_v);
        end
        n_checks++;
        if (count !== 5'd0 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_count_data count=%0d rd_data=%h exp 0/00", count, rd_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i - 1);
            step();
            n_checks++;
            if (count !== 5'(i) || full !== (i == 16) || almost_full !== (i >= 14)
                || almost_empty !== (i <= 2) || empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d count=%0d full=%b af=%b ae=%b empty=%b exp count=%0d full=%b af=%b ae=%b empty=0",
                         i, count, full, almost_full, almost_empty, empty, i, i == 16, i >= 14, i <= 2);
            end
        end
        idle();
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_data = 8'hAA;
        step();
        n_checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set ovf=%b count=%0d full=%b exp 1/16/1", overflow, count, full);
        end
        idle(); err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            n_fail++; $display("FAIL overflow_clr ovf=%b count=%0d exp 0/16", overflow, count);
        end
    endtask

    task automatic test_full_wr_rd();
        logic [7:0] exp_d;
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
        step();
        n_checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_wr_rd rd_data=%h vld=%b count=%0d ovf=%b exp 00/1/16/0",
                               rd_data, rd_valid, count, overflow);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 15) ? 8'(k + 1) : 8'h55;
            step();
            n_checks++;
            if (rd_data !== exp_d || rd_valid !== 1'b1 || count !== 5'(15 - k)) begin
                n_fail++; $display("FAIL drain_%0d rd_data=%h vld=%b count=%0d exp %h/1/%0d",
                                   k, rd_data, rd_valid, count, exp_d, 15 - k);
            end
        end
        idle();
        step();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h55 || empty !== 1'b1 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL drain_idle vld=%b rd_data=%h empty=%b unf=%b exp 0/55/1/0",
                               rd_valid, rd_data, empty, underflow);
        end
    endtask

    task automatic test_empty_wr_rd();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3C;
        step();
        idle();
        n_checks++;
        if (underflow !== 1'b1 || count !== 5'd1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
            n_fail++; $display("FAIL empty_wr_rd unf=%b count=%0d vld=%b empty=%b exp 1/1/0/0",
                               underflow, count, rd_valid, empty);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h3C || rd_valid !== 1'b1 || underflow !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_readback rd_data=%h vld=%b unf=%b empty=%b exp 3c/1/0/1",
                               rd_data, rd_valid, underflow, empty);
        end
        // New error in the same cycle as err_clr: set wins.
        rd_en = 1'b1; err_clr = 1'b1;
        step();
        idle();
        n_checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL set_wins unf=%b vld=%b exp 1/0", underflow, rd_valid);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++; $display("FAIL unf_clr unf=%b exp 0", underflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sb[$];
        logic [7:0] exp_d;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; rd_en = 1'b0; wr_data = 8'((i * 37 + 5) & 8'hFF);
            sb.push_back(wr_data);
            step();
            wr_en = 1'b0; rd_en = 1'b1;
            step();
            exp_d = sb.pop_front();
            n_checks++;
            if (rd_data !== exp_d || rd_valid !== 1'b1 || count !== 5'd0) begin
                n_fail++; $display("FAIL wrap_%0d rd_data=%h vld=%b count=%0d exp %h/1/0",
                                   i, rd_data, rd_valid, count, exp_d);
            end
        end
        idle();
        step();
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_flags ovf=%b unf=%b empty=%b exp 0/0/1", overflow, underflow, empty);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h90 + i);
            step();
        end
        n_checks++;
        if (count !== 5'd9 || almost_empty !== 1'b0) begin
            n_fail++; $display("FAIL pre_reset count=%0d ae=%b exp 9/0", count, almost_empty);
        end
        // Traffic during the reset cycle must not complete.
        reset_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        step();
        reset_n = 1'b1; idle();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset count=%0d empty=%b vld=%b rd_data=%h exp 0/1/0/00",
                               count, empty, rd_valid, rd_data);
        end
        step();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL post_reset count=%0d empty=%b unf=%b exp 0/1/0", count, empty, underflow);
        end
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h77 || rd_valid !== 1'b1 || empty !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_rw rd_data=%h vld=%b empty=%b exp 77/1/1", rd_data, rd_valid, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_wr_rd();
        test_empty_wr_rd();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
